// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for the pipelined immediate generator: request side
// (instruction + format select) and result side (immediate + illegal flag).
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [2:0]      imm_src;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm_ext;
    logic            imm_illegal;

    // master drives requests and consumes results; slave is the generator
    modport master (
        output in_valid, instruction, imm_src, out_ready,
        input  in_ready, out_valid, imm_ext, imm_illegal
    );

    modport slave (
        input  in_valid, instruction, imm_src, out_ready,
        output in_ready, out_valid, imm_ext, imm_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator (I/S/B/U/J/zimm, XLEN 32 or 64) behind a
// valid/ready handshake with a two-entry skid buffer and an illegal counter.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    imm_gen_pipe_if.slave      bus,
    output logic [CNT_W-1:0]   illegal_count
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] r_imm_reg, s_imm_reg;
    logic            r_ill_reg, s_ill_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;
    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            sh_f3, sh_op, sh_op32;

    logic acc, pop, in_ready, out_valid;
    logic load_r, load_r_from_s, load_s, cnt_inc;

    assign instr  = bus.instruction;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Shift forms are recognised by opcode as well as funct3, so loads and
    // JALR with funct3 001/101 keep the ordinary sign-extended immediate.
    assign sh_f3   = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign sh_op   = (opcode == 7'b0010011) && sh_f3;
    assign sh_op32 = (XLEN == 64) && (opcode == 7'b0011011) && sh_f3;

    always_comb begin
        dec_imm = '0;
        dec_ill = 1'b0;
        case (bus.imm_src)
            3'b000: begin
                if (sh_op && (XLEN == 64)) begin
                    dec_imm = XLEN'(instr[25:20]);
                end else if (sh_op || sh_op32) begin
                    // 5-bit shamt; bit 25 set would ask for a shift >= 32
                    dec_imm = XLEN'(instr[24:20]);
                    dec_ill = instr[25];
                end else begin
                    dec_imm = XLEN'($signed(instr[31:20]));
                end
            end
            3'b001:  dec_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            3'b010:  dec_imm = XLEN'($signed({instr[31:12], 12'b0}));
            3'b011:  dec_imm = XLEN'(instr[19:15]);
            3'b101:  dec_imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                               instr[11:8], 1'b0}));
            3'b110:  dec_imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                               instr[30:21], 1'b0}));
            default: begin
                dec_imm = '0;
                dec_ill = 1'b1;
            end
        endcase
    end

    assign in_ready  = (state_reg != TWO);
    assign out_valid = (state_reg != EMPTY);
    assign acc       = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        load_r        = 1'b0;
        load_r_from_s = 1'b0;
        load_s        = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (acc) begin
                        load_r     = 1'b1;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        load_r = 1'b1;
                    end else if (acc) begin
                        load_s     = 1'b1;
                        state_next = TWO;
                    end else if (pop) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        load_r_from_s = 1'b1;
                        state_next    = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // Flushed requests are neither stored nor counted.
    assign cnt_inc = acc && !flush && dec_ill && (cnt_reg != {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imm_reg <= '0;
            r_ill_reg <= 1'b0;
            s_imm_reg <= '0;
            s_ill_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            if (load_r) begin
                r_imm_reg <= dec_imm;
                r_ill_reg <= dec_ill;
            end else if (load_r_from_s) begin
                r_imm_reg <= s_imm_reg;
                r_ill_reg <= s_ill_reg;
            end
            if (load_s) begin
                s_imm_reg <= dec_imm;
                s_ill_reg <= dec_ill;
            end
            if (cnt_inc) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.imm_ext     = r_imm_reg;
    assign bus.imm_illegal = r_ill_reg;
    assign illegal_count   = cnt_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Lockstep bench for an XLEN=32/CNT_W=8 and an XLEN=64/CNT_W=2 instance,
// vector table plus backpressure, flush, reset and saturation sequences.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    logic [7:0] cnt32;
    logic [1:0] cnt64;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64)) b64 ();

    imm_gen_pipe #(.XLEN(32), .CNT_W(8)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32), .illegal_count(cnt32)
    );
    imm_gen_pipe #(.XLEN(64), .CNT_W(2)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64), .illegal_count(cnt64)
    );

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [31:0] e32;
        logic        i32;
        logic [63:0] e64;
        logic        i64;
    } vec_t;

    typedef struct {
        logic [31:0] e32;
        logic        i32;
        logic [63:0] e64;
        logic        i64;
    } exp_t;

    localparam int NV = 18;
    vec_t tbl [NV];
    exp_t sb [$];
    exp_t e;
    int n_checks = 0;
    int n_fail = 0;
    int n_pops = 0;
    int exp_cnt32 = 0;
    int exp_cnt64 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src);
        b32.in_valid = v;  b32.instruction = ins;  b32.imm_src = src;
        b64.in_valid = v;  b64.instruction = ins;  b64.imm_src = src;
    endtask

    task automatic set_ready(input logic r);
        b32.out_ready = r;
        b64.out_ready = r;
    endtask

    // Hold the request until both instances are ready, then record the
    // expected results; returns one cycle after the accepting edge.
    task automatic send(input vec_t v);
        int k;
        drive(1'b1, v.instr, v.src);
        k = 0;
        while (!(b32.in_ready && b64.in_ready) && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("send_in_ready", {63'b0, b32.in_ready && b64.in_ready}, 64'd1);
        if (b32.in_ready && b64.in_ready) begin
            sb.push_back('{v.e32, v.i32, v.e64, v.i64});
            if (v.i32 && exp_cnt32 < 255) exp_cnt32++;
            if (v.i64 && exp_cnt64 < 3)   exp_cnt64++;
        end
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 3'b000);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid32"}, {63'b0, b32.out_valid}, 64'd0);
        chk({tag, "_out_valid64"}, {63'b0, b64.out_valid}, 64'd0);
        chk({tag, "_in_ready32"}, {63'b0, b32.in_ready}, 64'd1);
        chk({tag, "_in_ready64"}, {63'b0, b64.in_ready}, 64'd1);
        chk({tag, "_imm32"}, {32'b0, b32.imm_ext}, 64'd0);
        chk({tag, "_imm64"}, b64.imm_ext, 64'd0);
        chk({tag, "_ill32"}, {63'b0, b32.imm_illegal}, 64'd0);
        chk({tag, "_ill64"}, {63'b0, b64.imm_illegal}, 64'd0);
        chk({tag, "_cnt32"}, {56'b0, cnt32}, 64'd0);
        chk({tag, "_cnt64"}, {62'b0, cnt64}, 64'd0);
    endtask

    // Scoreboard: compare whatever the outputs present on a cycle they pop.
    always @(negedge clk) begin
        if (rst_n && b32.out_valid && b32.out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got imm32=0x%0h, expected no output", b32.imm_ext);
            end else begin
                e = sb.pop_front();
                $display("pop imm32=0x%08h ill32=%0b imm64=0x%016h ill64=%0b",
                         b32.imm_ext, b32.imm_illegal, b64.imm_ext, b64.imm_illegal);
                chk("imm32", {32'b0, b32.imm_ext}, {32'b0, e.e32});
                chk("ill32", {63'b0, b32.imm_illegal}, {63'b0, e.i32});
                chk("imm64", b64.imm_ext, e.e64);
                chk("ill64", {63'b0, b64.imm_illegal}, {63'b0, e.i64});
                chk("valid64", {63'b0, b64.out_valid}, 64'd1);
                n_pops++;
            end
        end
    end

    initial begin
        logic [31:0] held;
        int p0;

        tbl[0]  = '{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0}; // ADDI -1
        tbl[1]  = '{32'h01F09093, 3'b000, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0}; // SLLI 31
        tbl[2]  = '{32'hFFF01083, 3'b000, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0}; // LH -1
        tbl[3]  = '{32'hFE000EE3, 3'b101, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0}; // B
        tbl[4]  = '{32'h0000006F, 3'b110, 32'h00000000, 1'b0, 64'h0000000000000000, 1'b0}; // J 0
        tbl[5]  = '{32'hFE00AFA3, 3'b001, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0}; // S -1
        tbl[6]  = '{32'h300F9073, 3'b011, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0}; // zimm
        tbl[7]  = '{32'h80000037, 3'b010, 32'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0}; // LUI
        tbl[8]  = '{32'h03F09093, 3'b000, 32'h0000001F, 1'b1, 64'h000000000000003F, 1'b0}; // SLLI 63
        tbl[9]  = '{32'hFFF05083, 3'b000, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0}; // LHU
        tbl[10] = '{32'h4010D093, 3'b000, 32'h00000001, 1'b0, 64'h0000000000000001, 1'b0}; // SRAI 1
        tbl[11] = '{32'h0010909B, 3'b000, 32'h00000001, 1'b0, 64'h0000000000000001, 1'b0}; // SLLIW 1
        tbl[12] = '{32'h0210909B, 3'b000, 32'h00000021, 1'b0, 64'h0000000000000001, 1'b1}; // SLLIW 33
        tbl[13] = '{32'h12345678, 3'b100, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1}; // bad fmt
        tbl[14] = '{32'hFFFFFFFF, 3'b111, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1}; // bad fmt
        tbl[15] = '{32'hFFFFF06F, 3'b110, 32'hFFFFFFFE, 1'b0, 64'hFFFFFFFFFFFFFFFE, 1'b0}; // J -2
        tbl[16] = '{32'h12345037, 3'b010, 32'h12345000, 1'b0, 64'h0000000012345000, 1'b0}; // LUI +
        tbl[17] = '{32'hFFFF8073, 3'b011, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0}; // zimm

        drive(1'b0, 32'h0, 3'b000);
        set_ready(1'b0);
        #1 rst_n = 1'b0;
        #3 chk_reset_state("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Streaming through the whole table, consumer always ready.
        set_ready(1'b1);
        for (int i = 0; i < NV; i++) begin
            send(tbl[i]);
            if (i == 0) begin
                chk("latency_valid", {63'b0, b32.out_valid}, 64'd1);
                chk("latency_imm", {32'b0, b32.imm_ext}, {32'b0, tbl[0].e32});
            end
        end
        drain();
        chk("table_cnt32", {56'b0, cnt32}, 64'(exp_cnt32));
        chk("table_cnt64", {62'b0, cnt64}, 64'(exp_cnt64));

        // Backpressure: A and B fill the buffer, C must wait.
        @(posedge clk); #1;
        set_ready(1'b0);
        send(tbl[3]);
        send(tbl[7]);
        chk("bp_in_ready", {63'b0, b32.in_ready}, 64'd0);
        held = b32.imm_ext;
        drive(1'b1, tbl[15].instr, tbl[15].src);
        repeat (2) begin
            @(posedge clk); #1;
            chk("bp_stall_ready", {63'b0, b32.in_ready}, 64'd0);
            chk("bp_hold_imm", {32'b0, b32.imm_ext}, {32'b0, held});
            chk("bp_hold_valid", {63'b0, b32.out_valid}, 64'd1);
        end
        p0 = n_pops;
        set_ready(1'b1);
        send(tbl[15]);
        @(negedge clk); #1;
        chk("bp_pop_count", 64'(n_pops - p0), 64'd3);
        @(negedge clk); #1;
        chk("bp_no_dup", {63'b0, b32.out_valid}, 64'd0);
        drain();

        // Flush while full: both entries and the incoming request vanish.
        set_ready(1'b0);
        send(tbl[2]);
        send(tbl[5]);
        flush = 1'b1;
        drive(1'b1, tbl[13].instr, tbl[13].src);
        @(posedge clk); #1;
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'b000);
        sb.delete();
        chk("flush_valid", {63'b0, b32.out_valid}, 64'd0);
        chk("flush_ready", {63'b0, b32.in_ready}, 64'd1);
        chk("flush_cnt32", {56'b0, cnt32}, 64'(exp_cnt32));
        // Flush from empty with an accepted illegal request: dropped, not counted.
        set_ready(1'b1);
        flush = 1'b1;
        drive(1'b1, tbl[14].instr, tbl[14].src);
        @(posedge clk); #1;
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'b000);
        @(posedge clk); #1;
        chk("flush_drop_valid", {63'b0, b32.out_valid}, 64'd0);
        chk("flush_drop_cnt32", {56'b0, cnt32}, 64'(exp_cnt32));
        chk("flush_drop_cnt64", {62'b0, cnt64}, 64'(exp_cnt64));
        send(tbl[16]);
        drain();

        // Asynchronous reset with the buffer full, checked before the next edge.
        set_ready(1'b0);
        send(tbl[0]);
        send(tbl[1]);
        #2 rst_n = 1'b0;
        #1 chk_reset_state("async_reset");
        sb.delete();
        exp_cnt32 = 0;
        exp_cnt64 = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Illegal counting and saturation of the 2-bit counter.
        set_ready(1'b1);
        repeat (3) send(tbl[13]);
        drain();
        chk("cnt32_after3", {56'b0, cnt32}, 64'd3);
        chk("cnt64_after3", {62'b0, cnt64}, 64'd3);
        repeat (2) send(tbl[13]);
        drain();
        chk("cnt32_after5", {56'b0, cnt32}, 64'd5);
        chk("cnt64_sat", {62'b0, cnt64}, 64'd3);
        chk("cnt32_model", {56'b0, cnt32}, 64'(exp_cnt32));

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
